// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks rd of in-flight loads and gates decode issue on
// load-use, WAW and outstanding-limit hazards.
module load_scoreboard #(
   parameter int MAX_OUT = 2,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             decValid,
   input  logic [4:0]       decRs1,
   input  logic [4:0]       decRs2,
   input  logic             decUsesRs1,
   input  logic             decUsesRs2,
   input  logic [4:0]       decRd,
   input  logic             decRegWrite,
   input  logic             decIsLoad,
   input  logic             exReady,
   input  logic             flush,
   input  logic             memRespValid,
   input  logic [4:0]       memRespRd,
   output logic             stall,
   output logic             issue,
   output logic [31:0]      pendingMask,
   output logic [CNT_W-1:0] outstanding,
   output logic             protoErr
);

   logic [31:0]      pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic hit1, hit2, hitRd;
   logic rawHaz, wawHaz, fullHaz;
   logic ldIssue;
   logic badResp;

   // A response returning this cycle is forwarded, so it never blocks.
   assign hit1  = decRs1 != 5'd0 && pend_q[decRs1] &&
                  !(memRespValid && memRespRd == decRs1);
   assign hit2  = decRs2 != 5'd0 && pend_q[decRs2] &&
                  !(memRespValid && memRespRd == decRs2);
   assign hitRd = decRd != 5'd0 && pend_q[decRd] &&
                  !(memRespValid && memRespRd == decRd);

   assign rawHaz  = decValid && ((decUsesRs1 && hit1) ||
                                 (decUsesRs2 && hit2));
   assign wawHaz  = decValid && decRegWrite && hitRd;
   assign fullHaz = decValid && decIsLoad &&
                    cnt_q == CNT_W'(MAX_OUT) && !memRespValid;

   assign stall   = rawHaz || wawHaz || fullHaz;
   assign issue   = decValid && !stall && exReady && !flush;
   assign ldIssue = issue && decIsLoad;

   assign badResp = memRespValid &&
                    (cnt_q == '0 ||
                     (memRespRd != 5'd0 && !pend_q[memRespRd]));

   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      err_d  = err_q | badResp;
      if (memRespValid && memRespRd != 5'd0)
         pend_d[memRespRd] = 1'b0;
      // Set after clear so a same-cycle reissue to the same rd wins.
      if (ldIssue && decRd != 5'd0)
         pend_d[decRd] = 1'b1;
      pend_d[0] = 1'b0;
      if (ldIssue && !memRespValid)
         cnt_d = cnt_q + CNT_W'(1);
      else if (!ldIssue && memRespValid && cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign pendingMask = pend_q;
   assign outstanding = cnt_q;
   assign protoErr    = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard: directed hazard scenarios plus
// random traffic against a set/queue-based reference model.
module tb_load_scoreboard;

   localparam int MAX_OUT = 2;
   localparam int CNT_W   = 3;

   logic             clk = 1'b0;
   logic             rstN;
   logic             decValid;
   logic [4:0]       decRs1, decRs2, decRd, memRespRd;
   logic             decUsesRs1, decUsesRs2, decRegWrite, decIsLoad;
   logic             exReady, flush, memRespValid;
   logic             stall, issue, protoErr;
   logic [31:0]      pendingMask;
   logic [CNT_W-1:0] outstanding;

   always #5 clk = ~clk;

   load_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstN(rstN),
      .decValid(decValid), .decRs1(decRs1), .decRs2(decRs2),
      .decUsesRs1(decUsesRs1), .decUsesRs2(decUsesRs2),
      .decRd(decRd), .decRegWrite(decRegWrite), .decIsLoad(decIsLoad),
      .exReady(exReady), .flush(flush),
      .memRespValid(memRespValid), .memRespRd(memRespRd),
      .stall(stall), .issue(issue), .pendingMask(pendingMask),
      .outstanding(outstanding), .protoErr(protoErr)
   );

   typedef struct {
      bit       v;
      bit [4:0] rs1, rs2, rd;
      bit       u1, u2, rw, ld, rdy, fl, rv;
      bit [4:0] rr;
   } in_t;

   typedef struct {
      bit        stall, issue, err;
      bit [31:0] mask;
      int        cnt;
   } exp_t;

   exp_t expq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: set of pending registers, load count, list of loads.
   bit pend[32];
   int cnt;
   bit perr;
   int inflight[$];

   function automatic in_t nop();
      in_t x;
      x = '{default: 0};
      x.rdy = 1'b1;
      return x;
   endfunction

   function automatic in_t ldi(bit [4:0] rd);
      in_t x;
      x = nop();
      x.v = 1; x.rd = rd; x.rw = 1; x.ld = 1; x.u1 = 1; x.rs1 = 5'd0;
      return x;
   endfunction

   function automatic in_t alu(bit [4:0] a, bit [4:0] b, bit [4:0] d,
                               bit ua, bit ub, bit w);
      in_t x;
      x = nop();
      x.v = 1; x.rs1 = a; x.rs2 = b; x.rd = d;
      x.u1 = ua; x.u2 = ub; x.rw = w;
      return x;
   endfunction

   function automatic in_t resp(in_t xi, bit [4:0] r);
      in_t x;
      x = xi;
      x.rv = 1; x.rr = r;
      return x;
   endfunction

   function automatic bit hitm(bit [4:0] r, in_t x);
      return r != 0 && pend[r] && !(x.rv && x.rr == r);
   endfunction

   task automatic apply(in_t x);
      decValid     = x.v;
      decRs1       = x.rs1;
      decRs2       = x.rs2;
      decRd        = x.rd;
      decUsesRs1   = x.u1;
      decUsesRs2   = x.u2;
      decRegWrite  = x.rw;
      decIsLoad    = x.ld;
      exReady      = x.rdy;
      flush        = x.fl;
      memRespValid = x.rv;
      memRespRd    = x.rr;
   endtask

   task automatic model_clear();
      foreach (pend[i]) pend[i] = 0;
      cnt = 0;
      perr = 0;
      inflight.delete();
   endtask

   task automatic step(in_t x);
      exp_t e;
      bit raw, waw, full, st, iss;
      int n;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      apply(x);
      raw  = x.v && ((x.u1 && hitm(x.rs1, x)) || (x.u2 && hitm(x.rs2, x)));
      waw  = x.v && x.rw && hitm(x.rd, x);
      full = x.v && x.ld && cnt == MAX_OUT && !x.rv;
      st   = raw || waw || full;
      iss  = x.v && !st && x.rdy && !x.fl;
      e.stall = st;
      e.issue = iss;
      e.cnt   = cnt;
      e.err   = perr;
      for (int i = 0; i < 32; i++) e.mask[i] = pend[i];
      expq.push_back(e);
      if (x.rv) begin
         if (cnt == 0) perr = 1;
         if (x.rr != 0 && !pend[x.rr]) perr = 1;
         if (x.rr != 0) pend[x.rr] = 0;
         foreach (inflight[i])
            if (inflight[i] == int'(x.rr)) begin
               inflight.delete(i);
               break;
            end
      end
      if (iss && x.ld) begin
         if (x.rd != 0) pend[x.rd] = 1;
         inflight.push_back(int'(x.rd));
      end
      n = cnt + ((iss && x.ld) ? 1 : 0) - (x.rv ? 1 : 0);
      cnt = (n < 0) ? 0 : n;
   endtask

   task automatic reset_cycle();
      exp_t e;
      @(posedge clk);
      #1;
      apply(nop());
      decValid = 1'b0;
      rstN = 1'b0;
      model_clear();
      e = '{default: 0};
      expq.push_back(e);
   endtask

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("issue", int'(issue), int'(e.issue));
            chk("pendingMask", int'(pendingMask), int'(e.mask));
            chk("outstanding", int'(outstanding), e.cnt);
            chk("protoErr", int'(protoErr), int'(e.err));
         end
      end
   end

   initial begin : driver
      in_t x;
      rstN = 1'b0;
      apply(nop());
      model_clear();
      reset_cycle();
      reset_cycle();
      // load-use: stall until response, issue in response cycle
      step(ldi(5));
      step(alu(5, 0, 6, 1, 0, 1));
      step(alu(5, 0, 6, 1, 0, 1));
      step(resp(alu(5, 0, 6, 1, 0, 1), 5));
      step(nop());
      // WAW on x7
      step(ldi(7));
      step(alu(0, 0, 7, 0, 0, 1));
      step(alu(0, 0, 7, 0, 0, 1));
      step(resp(alu(0, 0, 7, 0, 0, 1), 7));
      // load to x0
      step(ldi(0));
      step(nop());
      step(resp(nop(), 0));
      // outstanding limit
      step(ldi(1));
      step(ldi(2));
      step(ldi(3));
      step(resp(ldi(3), 1));
      step(nop());
      step(resp(nop(), 2));
      step(resp(nop(), 3));
      // same-cycle response and reissue to x4
      step(ldi(4));
      step(resp(ldi(4), 4));
      step(nop());
      step(resp(nop(), 4));
      // flush suppresses issue without state change
      x = ldi(9);
      x.fl = 1;
      step(x);
      step(nop());
      // mid-run reset with x5 pending
      step(ldi(5));
      step(nop());
      reset_cycle();
      step(alu(5, 0, 6, 1, 0, 1));
      step(nop());
      // protocol errors
      step(resp(nop(), 3));
      step(nop());
      step(nop());
      reset_cycle();
      step(ldi(3));
      step(resp(nop(), 6));
      step(nop());
      reset_cycle();
      // random traffic
      for (int c = 0; c < 2000; c++) begin
         x = nop();
         x.rdy = ($urandom % 5) != 0;
         if (inflight.size() > 0 && ($urandom % 3) == 0) begin
            x.rv = 1;
            x.rr = 5'(inflight[$urandom % inflight.size()]);
         end
         x.v   = ($urandom % 5) != 0;
         x.rs1 = 5'($urandom_range(0, 7));
         x.rs2 = 5'($urandom_range(0, 7));
         x.rd  = 5'($urandom_range(0, 7));
         x.u1  = 1'($urandom % 2);
         x.u2  = 1'($urandom % 2);
         x.ld  = ($urandom % 5) < 2;
         x.rw  = x.ld | 1'($urandom % 2);
         x.fl  = ($urandom % 10) == 0;
         step(x);
      end
      step(nop());
      repeat (3) @(posedge clk);
      if (expq.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d entries left, expected 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
